// File: rtl/byte_pair_packer.sv
// byte_pair_packer
//
// Packs consecutive bytes into 16-bit words and queues the words in a small
// FIFO. A frame with an odd number of bytes ends with a padded word whose
// upper byte is zero. Each frame's mod-2^WIDTH checksum is reported with a
// one-cycle pulse after its final byte is accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    byte from upstream
//   in_valid   in_data valid
//   in_last    byte ends the frame (qualified by in_valid)
//   in_ready   byte accepted this cycle when in_valid is high (FIFO not full)
//   out_data   packed word at FIFO head (first byte in the low half)
//   out_last   head word ends a frame
//   out_pad    head word upper byte is zero padding
//   out_valid  FIFO non-empty
//   out_ready  downstream consumes head word
//   sum_data   checksum of the most recent frame (held between frames)
//   sum_valid  one-cycle pulse, sum_data freshly updated
module byte_pair_packer #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = WIDTH * 2,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 out_pad,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum_data,
    output logic                 sum_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        HALF_EMPTY = 1'b0,
        HALF_FULL  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [WIDTH-1:0]     hold_r;
    logic [WIDTH-1:0]     acc_r;
    logic [WIDTH-1:0]     sum_data_r;
    logic                 sum_valid_r;

    logic [OUT_WIDTH-1:0] mem_data_r [DEPTH];
    logic                 mem_last_r [DEPTH];
    logic                 mem_pad_r  [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;

    logic                 accept_s;
    logic                 pop_s;
    logic                 push_s;
    logic [OUT_WIDTH-1:0] push_data_s;
    logic                 push_last_s;
    logic                 push_pad_s;

    // Ready depends only on registered occupancy, so a pop frees space one cycle later.
    assign in_ready  = (count_r != CW'(DEPTH));
    assign out_valid = (count_r != {CW{1'b0}});
    assign accept_s  = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    assign out_data  = mem_data_r[rd_ptr_r];
    assign out_last  = mem_last_r[rd_ptr_r];
    assign out_pad   = mem_pad_r[rd_ptr_r];
    assign sum_data  = sum_data_r;
    assign sum_valid = sum_valid_r;

    // Pairing state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= HALF_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Pairing next-state and FIFO push request.
    always_comb begin
        state_s     = state_r;
        push_s      = 1'b0;
        push_data_s = {OUT_WIDTH{1'b0}};
        push_last_s = 1'b0;
        push_pad_s  = 1'b0;
        if (accept_s) begin
            case (state_r)
                HALF_EMPTY: begin
                    if (in_last) begin
                        // Single leftover byte closes the frame as a padded word.
                        push_s      = 1'b1;
                        push_data_s = {{WIDTH{1'b0}}, in_data};
                        push_last_s = 1'b1;
                        push_pad_s  = 1'b1;
                        state_s     = HALF_EMPTY;
                    end else begin
                        state_s     = HALF_FULL;
                    end
                end
                HALF_FULL: begin
                    push_s      = 1'b1;
                    push_data_s = {in_data, hold_r};
                    push_last_s = in_last;
                    push_pad_s  = 1'b0;
                    state_s     = HALF_EMPTY;
                end
                default: begin
                    state_s = HALF_EMPTY;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Hold register captures the first byte of each pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_r <= {WIDTH{1'b0}};
        end else if (accept_s && (state_r == HALF_EMPTY)) begin
            hold_r <= in_data;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Word FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_r[i] <= {OUT_WIDTH{1'b0}};
                mem_last_r[i] <= 1'b0;
                mem_pad_r[i]  <= 1'b0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= push_data_s;
                mem_last_r[wr_ptr_r] <= push_last_s;
                mem_pad_r[wr_ptr_r]  <= push_pad_s;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame checksum accumulator and end-of-frame report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r       <= {WIDTH{1'b0}};
            sum_data_r  <= {WIDTH{1'b0}};
            sum_valid_r <= 1'b0;
        end else if (accept_s && in_last) begin
            acc_r       <= {WIDTH{1'b0}};
            sum_data_r  <= acc_r + in_data;
            sum_valid_r <= 1'b1;
        end else if (accept_s) begin
            acc_r       <= acc_r + in_data;
            sum_valid_r <= 1'b0;
        end else begin
            sum_valid_r <= 1'b0;
        end
    end

endmodule
